// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, shift-amount width and the
// sequential shifter FSM state encoding.
package alu_pkg;

  localparam int ALU_WIDTH   = 32;
  localparam int ALU_SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sll_state_t;

endpackage

// File: rtl/shift_left_step.sv
// One combinational step of the sequential SLL: shifts acc by min(STEP, rem).
// With SLL_CARRY_OUT_EN defined it also reports the last bit shifted out.
module shift_left_step
  import alu_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic [ALU_WIDTH-1:0]   acc,
  input  logic [ALU_SHAMT_W-1:0] rem,
`ifdef SLL_CARRY_OUT_EN
  output logic                   out_bit,
`endif
  output logic [ALU_WIDTH-1:0]   next_acc,
  output logic [ALU_SHAMT_W-1:0] next_rem
);

  // One extra bit so STEP=WIDTH is representable.
  localparam logic [ALU_SHAMT_W:0] STEP_AMT = STEP[ALU_SHAMT_W:0];

  logic [ALU_SHAMT_W:0] amt;

  always_comb begin
    amt = {1'b0, rem};
    if (amt > STEP_AMT) begin
      amt = STEP_AMT;
    end
  end

  assign next_acc = acc << amt;
  assign next_rem = rem - amt[ALU_SHAMT_W-1:0];

`ifdef SLL_CARRY_OUT_EN
  // The last bit out is the lowest of those leaving: acc[WIDTH-amt].
  logic [ALU_SHAMT_W-1:0] out_idx;
  assign out_idx = '0 - amt[ALU_SHAMT_W-1:0];
  assign out_bit = (amt == '0) ? 1'b0 : acc[out_idx];
`endif

endmodule

// File: rtl/shift_left_logical_seq.sv
// Multi-cycle 32-bit logical left shifter, STEP bits per cycle, start/busy/done.
// Define SLL_CARRY_OUT_EN to add carry-out port C (last bit shifted out).
module shift_left_logical_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
`ifdef SLL_CARRY_OUT_EN
  output logic             C,
`endif
  output logic [WIDTH-1:0] Z
);

  sll_state_t             state;
  logic [WIDTH-1:0]       acc;
  logic [ALU_SHAMT_W-1:0] rem;
  logic [WIDTH-1:0]       next_acc;
  logic [ALU_SHAMT_W-1:0] next_rem;
  logic                   oor;

  // Any bit above the 5-bit shift count means the result is all zero.
  assign oor = |Y[WIDTH-1:ALU_SHAMT_W];

`ifdef SLL_CARRY_OUT_EN
  logic carry;
  logic step_out;
`endif

  shift_left_step #(
    .STEP(STEP)
  ) u_step (
    .acc     (acc),
    .rem     (rem),
`ifdef SLL_CARRY_OUT_EN
    .out_bit (step_out),
`endif
    .next_acc(next_acc),
    .next_rem(next_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Z     <= '0;
`ifdef SLL_CARRY_OUT_EN
      carry <= 1'b0;
      C     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            rem  <= Y[ALU_SHAMT_W-1:0];
`ifdef SLL_CARRY_OUT_EN
            carry <= 1'b0;
`endif
            if (oor) begin
              acc   <= '0;
              state <= DONE;
            end else begin
              acc   <= X;
              state <= (Y[ALU_SHAMT_W-1:0] == '0) ? DONE : SHIFT;
            end
          end
        end
        SHIFT: begin
          acc <= next_acc;
          rem <= next_rem;
`ifdef SLL_CARRY_OUT_EN
          carry <= step_out;
`endif
          if (next_rem == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          Z     <= acc;
`ifdef SLL_CARRY_OUT_EN
          C     <= carry;
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
